stream_demux: RTL and testbench

//   Routes one valid/ready input stream to one of N_OUT output streams. This is the

---
 rtl/stream_demux_if.sv | 26 ++
 rtl/stream_demux.sv | 68 ++++++
 tb/tb_stream_demux.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// Valid/ready bundle for stream_demux: one input stream plus N_OUT registered output slots.
// The demux takes the slave modport; the upstream/downstream side takes master.
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
);
  localparam int SEL_W = $clog2(N_OUT);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_demux.sv
// Routes one valid/ready stream to N_OUT one-entry output slots, steered by a
// per-beat select or by a strict round-robin pointer.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rr_mode,
  output logic [7:0]   err_cnt,
  stream_demux_if.slave bus
);
  localparam int SEL_W = $clog2(N_OUT);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] tgt;
  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] hit;
  logic             in_range;
  logic             ready;
  logic             accept;

  assign tgt      = rr_mode ? rr_ptr : bus.in_sel;
  assign free     = ~bus.out_valid | bus.out_ready;
  assign in_range = 32'(tgt) < N_OUT;

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      hit[k] = (32'(tgt) == k);
    end
  end

  // Out-of-range selects are always accepted so a bad beat cannot wedge the stream.
  assign ready        = in_range ? |(hit & free) : 1'b1;
  assign bus.in_ready = ready;
  assign accept       = bus.in_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= '0;
      bus.out_data  <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (accept && hit[k]) begin
          bus.out_valid[k]                <= 1'b1;
          bus.out_data[k*WIDTH +: WIDTH]  <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          bus.out_valid[k]                <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      err_cnt <= '0;
    end else begin
      if (accept && rr_mode) begin
        rr_ptr <= (32'(rr_ptr) == N_OUT - 1) ? '0 : rr_ptr + SEL_W'(1);
      end
      if (accept && !in_range && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux: a 4-output instance for routing,
// back-pressure and throughput, and a 3-output instance for out-of-range selects.
module tb_stream_demux;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rr_mode;
  logic       rr_mode3;
  logic [7:0] err_cnt;
  logic [7:0] err_cnt3;

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0] expQ[4][$];
  int         modelPtr;
  int         nextData;
  int         recv[4];
  int         sbErrs;
  int         dutStalls;
  int         readyLow;
  int         validSeen;

  stream_demux_if #(.WIDTH(8), .N_OUT(4)) bus ();
  stream_demux_if #(.WIDTH(8), .N_OUT(3)) bus3 ();

  stream_demux #(.WIDTH(8), .N_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .err_cnt(err_cnt), .bus(bus)
  );

  stream_demux #(.WIDTH(8), .N_OUT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode3), .err_cnt(err_cnt3), .bus(bus3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic [1:0] sel, input logic mode);
    bus.in_valid = valid;
    bus.in_data  = data;
    bus.in_sel   = sel;
    rr_mode      = mode;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] slot(input int k);
    return bus.out_data[k*8 +: 8];
  endfunction

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < 4; k++) n += expQ[k].size();
    return n;
  endfunction

  // Round-robin traffic with a queue-per-output scoreboard; the model predicts
  // slot occupancy, in_ready and the target of every accepted beat.
  task automatic runTraffic(input int beats, input bit randomReady);
    int   issued = 0;
    int   cycles = 0;
    logic expReady;
    logic [7:0] d;
    while ((issued < beats || pending() != 0) && cycles < beats * 4 + 50) begin
      for (int k = 0; k < 4; k++) bus.out_ready[k] = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(issued < beats, 8'(nextData), 2'(3 - (issued % 4)), 1'b1);
      #1;
      expReady = (expQ[modelPtr].size() == 0) || bus.out_ready[modelPtr];
      if (bus.in_ready !== expReady) sbErrs++;
      if (bus.in_valid && !bus.in_ready) dutStalls++;
      for (int k = 0; k < 4; k++) begin
        if (bus.out_valid[k] !== (expQ[k].size() != 0)) sbErrs++;
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          if (expQ[k].size() == 0) begin
            sbErrs++;
          end else begin
            d = expQ[k].pop_front();
            if (slot(k) !== d) sbErrs++;
            recv[k]++;
          end
        end
      end
      if (bus.in_valid && expReady) begin
        expQ[modelPtr].push_back(8'(nextData));
        nextData++;
        issued++;
        modelPtr = (modelPtr + 1) % 4;
      end
      step();
      cycles++;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
    bus.out_ready  = 4'h0;
    bus3.in_valid  = 1'b0;
    bus3.in_data   = 8'h00;
    bus3.in_sel    = 2'd0;
    bus3.out_ready = 3'b111;
    rr_mode3       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);
    checkOutput("rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Mid-traffic reset with slots 0, 1 and 3 held
    applyStimulus(1'b1, 8'h10, 2'd2, 1'b1);
    step();
    applyStimulus(1'b1, 8'h21, 2'd1, 1'b0);
    step();
    applyStimulus(1'b1, 8'h43, 2'd3, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
    checkOutput("fill_out_valid", 32'(bus.out_valid), 32'hB);
    checkOutput("fill_rr_ptr", 32'(dut.rr_ptr), 32'h1);
    checkOutput("fill_slot0", 32'(slot(0)), 32'h10);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("async_err_cnt", 32'(err_cnt), 32'h0);
    checkOutput("async_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("post_rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    checkOutput("post_rst_slot0", 32'(slot(0)), 32'h0);

    // Select routing
    bus.out_ready = 4'hF;
    applyStimulus(1'b1, 8'h11, 2'd2, 1'b0);
    step();
    checkOutput("sel_v1", 32'(bus.out_valid), 32'h4);
    checkOutput("sel_d1", 32'(slot(2)), 32'h11);
    applyStimulus(1'b1, 8'h22, 2'd0, 1'b0);
    step();
    checkOutput("sel_v2", 32'(bus.out_valid), 32'h1);
    checkOutput("sel_d2", 32'(slot(0)), 32'h22);
    applyStimulus(1'b1, 8'h33, 2'd2, 1'b0);
    step();
    checkOutput("sel_v3", 32'(bus.out_valid), 32'h4);
    checkOutput("sel_d3", 32'(slot(2)), 32'h33);
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    checkOutput("sel_idle", 32'(bus.out_valid), 32'h0);

    // Back-pressure on output 1
    bus.out_ready = 4'b1101;
    applyStimulus(1'b1, 8'hA0, 2'd1, 1'b0);
    #1;
    checkOutput("bp_ready_a0", 32'(bus.in_ready), 32'h1);
    step();
    checkOutput("bp_v_a0", 32'(bus.out_valid), 32'h2);
    checkOutput("bp_d_a0", 32'(slot(1)), 32'hA0);
    applyStimulus(1'b1, 8'hA1, 2'd1, 1'b0);
    #1;
    checkOutput("bp_stall_a1", 32'(bus.in_ready), 32'h0);
    step();
    checkOutput("bp_hold_v", 32'(bus.out_valid), 32'h2);
    checkOutput("bp_hold_d", 32'(slot(1)), 32'hA0);
    applyStimulus(1'b0, 8'hB0, 2'd3, 1'b0);
    #1;
    checkOutput("bp_other_free", 32'(bus.in_ready), 32'h1);
    applyStimulus(1'b1, 8'hA1, 2'd1, 1'b0);
    bus.out_ready = 4'hF;
    #1;
    checkOutput("bp_release", 32'(bus.in_ready), 32'h1);
    step();
    checkOutput("bp_v_a1", 32'(bus.out_valid), 32'h2);
    checkOutput("bp_d_a1", 32'(slot(1)), 32'hA1);
    applyStimulus(1'b1, 8'hB0, 2'd3, 1'b0);
    step();
    checkOutput("bp_v_b0", 32'(bus.out_valid), 32'h8);
    checkOutput("bp_d_b0", 32'(slot(3)), 32'hB0);
    checkOutput("bp_slot1_kept", 32'(slot(1)), 32'hA1);
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
    step();
    checkOutput("bp_idle", 32'(bus.out_valid), 32'h0);

    // Round-robin wrap, in_sel deliberately wrong to show it is ignored
    applyStimulus(1'b1, 8'h00, 2'd3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput($sformatf("rr_v%0d", i), 32'(bus.out_valid), 32'(1 << (i % 4)));
      checkOutput($sformatf("rr_d%0d", i), 32'(slot(i % 4)), 32'(i));
      if (i < 5) applyStimulus(1'b1, 8'(i + 1), 2'd3, 1'b1);
      else applyStimulus(1'b0, 8'h00, 2'd0, 1'b1);
    end
    checkOutput("rr_ptr_wrap", 32'(dut.rr_ptr), 32'h2);
    bus.out_ready = 4'b1011;
    applyStimulus(1'b1, 8'h66, 2'd2, 1'b0);
    step();
    checkOutput("rr_fill2_v", 32'(bus.out_valid), 32'h4);
    checkOutput("rr_ptr_sel_mode", 32'(dut.rr_ptr), 32'h2);
    applyStimulus(1'b1, 8'h77, 2'd0, 1'b1);
    #1;
    checkOutput("rr_strict_stall", 32'(bus.in_ready), 32'h0);
    step();
    checkOutput("rr_held_d", 32'(slot(2)), 32'h66);
    checkOutput("rr_ptr_stall", 32'(dut.rr_ptr), 32'h2);
    bus.out_ready = 4'hF;
    #1;
    checkOutput("rr_unstall", 32'(bus.in_ready), 32'h1);
    step();
    checkOutput("rr_refill_v", 32'(bus.out_valid), 32'h4);
    checkOutput("rr_refill_d", 32'(slot(2)), 32'h77);
    checkOutput("rr_ptr_after", 32'(dut.rr_ptr), 32'h3);
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b1);
    step();
    checkOutput("rr_idle", 32'(bus.out_valid), 32'h0);

    // Full throughput, all sinks ready
    modelPtr  = 3;
    nextData  = 0;
    sbErrs    = 0;
    dutStalls = 0;
    for (int k = 0; k < 4; k++) recv[k] = 0;
    runTraffic(100, 1'b0);
    checkOutput("tp_stalls", 32'(dutStalls), 32'h0);
    checkOutput("tp_scoreboard", 32'(sbErrs), 32'h0);
    checkOutput("tp_pending", 32'(pending()), 32'h0);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("tp_recv%0d", k), 32'(recv[k]), 32'd25);

    // Randomized sink readiness
    sbErrs = 0;
    for (int k = 0; k < 4; k++) recv[k] = 0;
    runTraffic(200, 1'b1);
    checkOutput("rnd_scoreboard", 32'(sbErrs), 32'h0);
    checkOutput("rnd_pending", 32'(pending()), 32'h0);
    checkOutput("rnd_total", 32'(recv[0] + recv[1] + recv[2] + recv[3]), 32'd200);

    // Out-of-range selects on the 3-output build
    readyLow  = 0;
    validSeen = 0;
    bus3.in_valid = 1'b1;
    bus3.in_sel   = 2'd3;
    for (int i = 0; i < 300; i++) begin
      bus3.in_data = 8'(i);
      #1;
      if (bus3.in_ready !== 1'b1) readyLow++;
      if (bus3.out_valid !== 3'b000) validSeen++;
      step();
      if (i == 99) checkOutput("oor_err_100", 32'(err_cnt3), 32'd100);
    end
    checkOutput("oor_ready_low", 32'(readyLow), 32'h0);
    checkOutput("oor_valid_seen", 32'(validSeen), 32'h0);
    checkOutput("oor_final_valid", 32'(bus3.out_valid), 32'h0);
    checkOutput("oor_err_sat", 32'(err_cnt3), 32'd255);
    bus3.in_sel  = 2'd2;
    bus3.in_data = 8'h5A;
    step();
    bus3.in_valid = 1'b0;
    checkOutput("n3_route_v", 32'(bus3.out_valid), 32'h4);
    checkOutput("n3_route_d", 32'(bus3.out_data[23:16]), 32'h5A);
    checkOutput("n3_err_hold", 32'(err_cnt3), 32'd255);

    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("n3_async_err", 32'(err_cnt3), 32'h0);
    checkOutput("n3_async_valid", 32'(bus3.out_valid), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
